// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the fetch port, the data port, the memory side and the
// conflict counter of the memory arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the
// requesters and the memory that surround it.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic [7:0]    conf_cnt;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output f_gnt, f_done, d_gnt, d_done, rdata, m_en, m_we, m_addr, m_wdata, conf_cnt
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  f_gnt, f_done, d_gnt, d_done, rdata, m_en, m_we, m_addr, m_wdata, conf_cnt
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: arbitrates an instruction-fetch port and a data (load/store) port onto
// one memory with a fixed read latency of WAIT_CYC cycles.
// Every transaction walks IDLE -> ACC (WAIT_CYC cycles) -> RESP -> IDLE.
// Optional feature macro MEM_ARB_RR_EN: when defined, simultaneous requests are
// settled round-robin; when undefined the data port has fixed priority.
module mem_arb #(
  parameter int WAIT_CYC = 1,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Value of the ACC cycle counter in the last ACC cycle.
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_t        state_q, state_d;
  logic [3:0]    waitCnt_q, waitCnt_d;
  logic          fetchWin_q, fetchWin_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    confCnt_q, confCnt_d;
  logic          anyReq;
  logic          bothReq;
  logic          pickFetch;
`ifdef MEM_ARB_RR_EN
  logic          lastData_q, lastData_d;
`endif

  assign anyReq  = bus.f_req | bus.d_req;
  assign bothReq = bus.f_req & bus.d_req;

`ifdef MEM_ARB_RR_EN
  // On a tie, hand memory to whichever port was not served last.
  always_comb begin
    pickFetch = bus.f_req;
    if (bothReq) begin
      pickFetch = lastData_q;
    end
  end
`else
  // Data port wins every tie; fetch only gets memory when data is quiet.
  always_comb begin
    pickFetch = bus.f_req & ~bus.d_req;
  end
`endif

  // State and transaction registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      fetchWin_q <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      confCnt_q  <= 8'd0;
`ifdef MEM_ARB_RR_EN
      lastData_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      fetchWin_q <= fetchWin_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      confCnt_q  <= confCnt_d;
`ifdef MEM_ARB_RR_EN
      lastData_q <= lastData_d;
`endif
    end
  end

  // Next-state logic: latch the winner in IDLE, count out the memory latency in
  // ACC, capture read data on the way out of ACC, and always return from RESP.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    fetchWin_d = fetchWin_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    confCnt_d  = confCnt_q;
`ifdef MEM_ARB_RR_EN
    lastData_d = lastData_q;
`endif

    if (state_q == IDLE && bothReq && confCnt_q != 8'hFF) begin
      confCnt_d = confCnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          state_d    = ACC;
          waitCnt_d  = 4'd0;
          fetchWin_d = pickFetch;
          addr_d     = pickFetch ? bus.f_addr : bus.d_addr;
          we_d       = pickFetch ? 1'b0 : bus.d_we;
          wdata_d    = pickFetch ? '0 : bus.d_wdata;
`ifdef MEM_ARB_RR_EN
          lastData_d = ~pickFetch;
`endif
        end
      end
      ACC: begin
        if (waitCnt_q == LAST_CNT) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = bus.m_rdata;
          end
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: grant spans ACC and RESP, done marks RESP, the strobe marks the
  // first ACC cycle only.
  always_comb begin
    bus.f_gnt    = 1'b0;
    bus.d_gnt    = 1'b0;
    bus.f_done   = 1'b0;
    bus.d_done   = 1'b0;
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = addr_q;
    bus.m_wdata  = wdata_q;
    bus.rdata    = rdata_q;
    bus.conf_cnt = confCnt_q;
    if (state_q != IDLE) begin
      bus.f_gnt = fetchWin_q;
      bus.d_gnt = ~fetchWin_q;
    end
    if (state_q == RESP) begin
      bus.f_done = fetchWin_q;
      bus.d_done = ~fetchWin_q;
    end
    if (state_q == ACC && waitCnt_q == 4'd0) begin
      bus.m_en = 1'b1;
      bus.m_we = we_q;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb.
// dut1 runs with a one-cycle memory, dut3 with a three-cycle memory; each gets a
// small memory device that only presents valid read data in the cycle the
// arbiter is meant to capture it, and garbage otherwise.
module tb_mem_arb;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int W1 = 1;
  localparam int W3 = 3;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] memDev [logic [AW-1:0]];
  logic [DW-1:0] refMem [logic [AW-1:0]];
  int age1 = 255;
  int age3 = 255;

  mem_arb_if #(.AW(AW), .DW(DW)) bus1 ();
  mem_arb_if #(.AW(AW), .DW(DW)) bus3 ();

  mem_arb #(.WAIT_CYC(W1), .AW(AW), .DW(DW)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
  mem_arb #(.WAIT_CYC(W3), .AW(AW), .DW(DW)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  always #5 clk = ~clk;

  // Contents of a memory word that nobody has stored to yet.
  function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] devRead(input logic [AW-1:0] a);
    return memDev.exists(a) ? memDev[a] : initVal(a);
  endfunction

  function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  // Memory device for dut1: data is valid only WAIT_CYC-1 cycles after the strobe cycle.
  always @(negedge clk) begin
    if (bus1.m_en) age1 = 0;
    else if (age1 < 255) age1 = age1 + 1;
    if (bus1.m_en && bus1.m_we) memDev[bus1.m_addr] = bus1.m_wdata;
    bus1.m_rdata = (age1 == W1 - 1) ? devRead(bus1.m_addr) : ~devRead(bus1.m_addr);
  end

  // Memory device for dut3, same behaviour with the longer latency.
  always @(negedge clk) begin
    if (bus3.m_en) age3 = 0;
    else if (age3 < 255) age3 = age3 + 1;
    if (bus3.m_en && bus3.m_we) memDev[bus3.m_addr] = bus3.m_wdata;
    bus3.m_rdata = (age3 == W3 - 1) ? devRead(bus3.m_addr) : ~devRead(bus3.m_addr);
  end

  // Drive all requester inputs of dut1 in one go.
  task automatic applyStimulus(input logic fReq, input logic [AW-1:0] fAddr, input logic dReq,
                               input logic dWe, input logic [AW-1:0] dAddr,
                               input logic [DW-1:0] dWdata);
    bus1.f_req   = fReq;
    bus1.f_addr  = fAddr;
    bus1.d_req   = dReq;
    bus1.d_we    = dWe;
    bus1.d_addr  = dAddr;
    bus1.d_wdata = dWdata;
  endtask

  // Pulse reset on dut1 with requests quiet, leaving it idle at a falling edge.
  task automatic resetDut1();
    @(negedge clk);
    rst1 = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
  endtask

  // Everything reads zero while reset is held, even with requests pending.
  task automatic test_reset();
    rst1 = 1'b1;
    rst3 = 1'b1;
    applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0040, 16'hFFFF);
    bus3.f_req = 1'b0; bus3.f_addr = '0; bus3.d_req = 1'b0;
    bus3.d_we = 1'b0; bus3.d_addr = '0; bus3.d_wdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus1.f_gnt, bus1.d_gnt, bus1.f_done, bus1.d_done, bus1.m_en, bus1.m_we} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {bus1.f_gnt, bus1.d_gnt, bus1.f_done, bus1.d_done, bus1.m_en, bus1.m_we});
    end
    total++;
    if ({bus1.m_addr, bus1.m_wdata, bus1.rdata, bus1.conf_cnt} !== 56'h0) begin
      bad++;
      $display("[TB] FAIL reset_data: addr=%h wdata=%h rdata=%h conf=%0d want all 0",
               bus1.m_addr, bus1.m_wdata, bus1.rdata, bus1.conf_cnt);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    total++;
    if ({bus1.f_gnt, bus1.d_gnt, bus1.m_en, bus1.conf_cnt} !== 11'h0) begin
      bad++;
      $display("[TB] FAIL reset_release: gnt=%b%b m_en=%b conf=%0d want 0",
               bus1.f_gnt, bus1.d_gnt, bus1.m_en, bus1.conf_cnt);
    end
  endtask

  // Single fetch: strobe one cycle after sampling, done plus data the cycle after.
  task automatic test_fetch();
    memDev[16'h0010] = 16'hA5A5;
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if ({bus1.m_en, bus1.m_we, bus1.f_gnt, bus1.d_gnt, bus1.f_done} !== 5'b10100 ||
        bus1.m_addr !== 16'h0010) begin
      bad++;
      $display("[TB] FAIL fetch_acc: en/we/fg/dg/fd=%b addr=%h want 10100 addr=0010",
               {bus1.m_en, bus1.m_we, bus1.f_gnt, bus1.d_gnt, bus1.f_done}, bus1.m_addr);
    end
    @(negedge clk);
    total++;
    if ({bus1.f_done, bus1.f_gnt, bus1.m_en} !== 3'b110 || bus1.rdata !== 16'hA5A5) begin
      bad++;
      $display("[TB] FAIL fetch_resp: done/gnt/en=%b rdata=%h want 110 rdata=a5a5",
               {bus1.f_done, bus1.f_gnt, bus1.m_en}, bus1.rdata);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if ({bus1.f_done, bus1.f_gnt} !== 2'b00 || bus1.rdata !== 16'hA5A5) begin
      bad++;
      $display("[TB] FAIL fetch_idle: done/gnt=%b rdata=%h want 00 rdata=a5a5",
               {bus1.f_done, bus1.f_gnt}, bus1.rdata);
    end
  endtask

  // Single store: write strobe with address and data, done, read data untouched.
  task automatic test_store();
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0040, 16'h1234);
    @(negedge clk);
    total++;
    if ({bus1.m_en, bus1.m_we, bus1.d_gnt, bus1.f_gnt} !== 4'b1110 ||
        bus1.m_addr !== 16'h0040 || bus1.m_wdata !== 16'h1234) begin
      bad++;
      $display("[TB] FAIL store_acc: en/we/dg/fg=%b addr=%h wdata=%h want 1110 0040 1234",
               {bus1.m_en, bus1.m_we, bus1.d_gnt, bus1.f_gnt}, bus1.m_addr, bus1.m_wdata);
    end
    @(negedge clk);
    total++;
    if ({bus1.d_done, bus1.f_done, bus1.m_en, bus1.m_we} !== 4'b1000 ||
        bus1.rdata !== 16'hA5A5) begin
      bad++;
      $display("[TB] FAIL store_resp: dd/fd/en/we=%b rdata=%h want 1000 rdata=a5a5",
               {bus1.d_done, bus1.f_done, bus1.m_en, bus1.m_we}, bus1.rdata);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (devRead(16'h0040) !== 16'h1234 || bus1.d_gnt !== 1'b0) begin
      bad++;
      $display("[TB] FAIL store_mem: mem[0040]=%h d_gnt=%b want 1234 0",
               devRead(16'h0040), bus1.d_gnt);
    end
  endtask

  // Both ports held high across three back-to-back transactions.
  task automatic test_conflict();
    logic [2:0] expF;
`ifdef MEM_ARB_RR_EN
    expF = 3'b101;
`else
    expF = 3'b000;
`endif
    resetDut1();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0104, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bus1.f_gnt, bus1.d_gnt} !== {expF[k], ~expF[k]}) begin
        bad++;
        $display("[TB] FAIL conflict_gnt%0d: f/d gnt=%b%b want %b%b", k,
                 bus1.f_gnt, bus1.d_gnt, expF[k], ~expF[k]);
      end
      @(negedge clk);
      total++;
      if ({bus1.f_done, bus1.d_done} !== {expF[k], ~expF[k]} ||
          bus1.rdata !== devRead(expF[k] ? 16'h0100 : 16'h0104)) begin
        bad++;
        $display("[TB] FAIL conflict_done%0d: f/d done=%b%b rdata=%h want %b%b %h", k,
                 bus1.f_done, bus1.d_done, bus1.rdata, expF[k], ~expF[k],
                 devRead(expF[k] ? 16'h0100 : 16'h0104));
      end
      if (k == 2) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      else @(negedge clk);
    end
    @(negedge clk);
    total++;
    if (bus1.conf_cnt !== 8'd3 || {bus1.f_gnt, bus1.d_gnt} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL conflict_cnt: conf=%0d gnt=%b%b want 3 00",
               bus1.conf_cnt, bus1.f_gnt, bus1.d_gnt);
    end
  endtask

  // 300 conflict cycles: the counter climbs one per conflict and sticks at 255.
  task automatic test_conf_sat();
    resetDut1();
    applyStimulus(1'b1, 16'h0108, 1'b1, 1'b0, 16'h010C, '0);
    for (int n = 1; n <= 300; n++) begin
      repeat (3) @(negedge clk);
      if (n == 100 || n == 254 || n == 255 || n == 300) begin
        total++;
        if (bus1.conf_cnt !== 8'((n > 255) ? 255 : n)) begin
          bad++;
          $display("[TB] FAIL conf_sat_%0d: conf=%0d want %0d", n, bus1.conf_cnt,
                   (n > 255) ? 255 : n);
        end
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  // Random requesters against a transaction-level model: a transaction sampled at
  // an edge owns memory for WAIT_CYC+2 cycles; strobe in its first cycle, done in
  // its last busy cycle, read data taken from the reference memory.
  task automatic test_random();
    logic busy, winF, tWe, lastD, fReq, dReq, fOwed, dOwed, dWe;
    logic expEn, expWe, expFg, expDg, expFd, expDd;
    logic [AW-1:0] tAddr, fAddr, dAddr;
    logic [DW-1:0] tWdata, dWdata, expRdata;
    int age, expConf;
    resetDut1();
    busy = 1'b0; winF = 1'b0; tWe = 1'b0; lastD = 1'b1; age = 0;
    fReq = 1'b0; dReq = 1'b0; fOwed = 1'b0; dOwed = 1'b0; dWe = 1'b0;
    tAddr = '0; fAddr = '0; dAddr = '0; tWdata = '0; dWdata = '0;
    expRdata = '0; expConf = 0;
    for (int i = 0; i < 400; i++) begin
      expEn = busy && age == 0;
      expWe = expEn && tWe;
      expFg = busy && winF;
      expDg = busy && !winF;
      expFd = busy && winF && age == W1;
      expDd = busy && !winF && age == W1;
      total++;
      if ({bus1.f_gnt, bus1.d_gnt, bus1.f_done, bus1.d_done, bus1.m_en, bus1.m_we} !==
          {expFg, expDg, expFd, expDd, expEn, expWe}) begin
        bad++;
        $display("[TB] FAIL rand_ctrl cyc %0d: fg/dg/fd/dd/en/we=%b want %b", i,
                 {bus1.f_gnt, bus1.d_gnt, bus1.f_done, bus1.d_done, bus1.m_en, bus1.m_we},
                 {expFg, expDg, expFd, expDd, expEn, expWe});
      end
      if (busy && age < W1) begin
        total++;
        if (bus1.m_addr !== tAddr || bus1.m_wdata !== tWdata) begin
          bad++;
          $display("[TB] FAIL rand_bus cyc %0d: addr=%h wdata=%h want %h %h", i,
                   bus1.m_addr, bus1.m_wdata, tAddr, tWdata);
        end
      end
      total++;
      if (bus1.rdata !== expRdata || bus1.conf_cnt !== 8'(expConf)) begin
        bad++;
        $display("[TB] FAIL rand_data cyc %0d: rdata=%h conf=%0d want %h %0d", i,
                 bus1.rdata, bus1.conf_cnt, expRdata, expConf);
      end
      if (expFd) begin
        fReq = 1'b0; fOwed = 1'b0;
      end else if (fOwed && fReq && $urandom_range(0, 3) == 0) begin
        fReq = 1'b0;
      end else if (!fReq && !fOwed && $urandom_range(0, 1) == 1) begin
        fReq = 1'b1; fAddr = 16'h0200 + 16'($urandom_range(0, 7));
      end
      if (expDd) begin
        dReq = 1'b0; dOwed = 1'b0;
      end else if (dOwed && dReq && $urandom_range(0, 3) == 0) begin
        dReq = 1'b0;
      end else if (!dReq && !dOwed && $urandom_range(0, 1) == 1) begin
        dReq = 1'b1; dWe = 1'($urandom_range(0, 1));
        dAddr = 16'h0200 + 16'($urandom_range(0, 7)); dWdata = 16'($urandom);
      end
      applyStimulus(fReq, fAddr, dReq, dWe, dAddr, dWdata);
      if (busy) begin
        if (age == W1 - 1 && !tWe) expRdata = refRead(tAddr);
        if (age == W1) busy = 1'b0;
        else age++;
      end else begin
        if (fReq && dReq && expConf < 255) expConf++;
        if (fReq || dReq) begin
`ifdef MEM_ARB_RR_EN
          winF = (fReq && dReq) ? lastD : fReq;
`else
          winF = fReq && !dReq;
`endif
          lastD  = !winF;
          busy   = 1'b1;
          age    = 0;
          tAddr  = winF ? fAddr : dAddr;
          tWe    = winF ? 1'b0 : dWe;
          tWdata = winF ? '0 : dWdata;
          if (winF) fOwed = 1'b1;
          else dOwed = 1'b1;
          if (tWe) refMem[tAddr] = tWdata;
        end
      end
      @(negedge clk);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (4) @(negedge clk);
  endtask

  // Longer latency: reset in the second ACC cycle kills the transaction silently,
  // then a fresh tie is arbitrated from the reset pointer and completes normally.
  task automatic test_reset_mid();
    logic expF;
    logic [AW-1:0] winAddr;
`ifdef MEM_ARB_RR_EN
    expF = 1'b1;
`else
    expF = 1'b0;
`endif
    bus3.f_req = 1'b1; bus3.f_addr = 16'h0020;
    @(negedge clk);
    total++;
    if ({bus3.m_en, bus3.f_gnt} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL mid_acc1: en/gnt=%b want 11", {bus3.m_en, bus3.f_gnt});
    end
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    total++;
    if ({bus3.f_gnt, bus3.d_gnt, bus3.f_done, bus3.d_done, bus3.m_en, bus3.m_we} !== 6'b0 ||
        {bus3.m_addr, bus3.m_wdata, bus3.rdata, bus3.conf_cnt} !== 56'h0) begin
      bad++;
      $display("[TB] FAIL mid_abort: ctrl=%b addr=%h wdata=%h rdata=%h conf=%0d want 0",
               {bus3.f_gnt, bus3.d_gnt, bus3.f_done, bus3.d_done, bus3.m_en, bus3.m_we},
               bus3.m_addr, bus3.m_wdata, bus3.rdata, bus3.conf_cnt);
    end
    bus3.f_req = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if ({bus3.f_done, bus3.d_done, bus3.f_gnt, bus3.d_gnt} !== 4'b0) begin
        bad++;
        $display("[TB] FAIL mid_quiet%0d: done/gnt=%b want 0000", k,
                 {bus3.f_done, bus3.d_done, bus3.f_gnt, bus3.d_gnt});
      end
    end
    bus3.f_req = 1'b1; bus3.f_addr = 16'h0021;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 16'h0022;
    winAddr = expF ? 16'h0021 : 16'h0022;
    for (int k = 0; k <= W3; k++) begin
      @(negedge clk);
      total++;
      if ({bus3.f_gnt, bus3.d_gnt, bus3.m_en, bus3.f_done, bus3.d_done} !==
          {expF, ~expF, k == 0, expF && k == W3, !expF && k == W3}) begin
        bad++;
        $display("[TB] FAIL mid_fresh%0d: fg/dg/en/fd/dd=%b want %b", k,
                 {bus3.f_gnt, bus3.d_gnt, bus3.m_en, bus3.f_done, bus3.d_done},
                 {expF, ~expF, k == 0, expF && k == W3, !expF && k == W3});
      end
    end
    total++;
    if (bus3.rdata !== devRead(winAddr) || bus3.conf_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL mid_rdata: rdata=%h conf=%0d want %h 1",
               bus3.rdata, bus3.conf_cnt, devRead(winAddr));
    end
    bus3.f_req = 1'b0;
    bus3.d_req = 1'b0;
    @(negedge clk);
  endtask

  // Run every scenario in turn, then report.
  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_conf_sat();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
